// File: rtl/clk_ratio_detect_if.sv
// Measurement bus of clk_ratio_detect: the sampled clock in, period/lock results out.
interface clk_ratio_detect_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_vld;
  logic             locked;
  logic             ratio_err;
  logic             timeout;

  modport master (
    output clk_in,
    input  period, high_time, period_vld, locked, ratio_err, timeout
  );

  modport slave (
    input  clk_in,
    output period, high_time, period_vld, locked, ratio_err, timeout
  );
endinterface

// File: rtl/clk_ratio_detect.sv
// On-chip checker for a divided clock: measures period and high time in
// clk_200K cycles, declares lock on a stable ratio, flags changes and stalls.
module clk_ratio_detect #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned SYNC_EN = 0
) (
  input  logic             clk_200K,
  input  logic             rst,
  clk_ratio_detect_if.slave bus
);

  localparam int unsigned    MW      = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [MW-1:0]  LOCK_M  = MW'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MEAS, TRACK} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic             s, s_d, rise;
  logic [CNT_W-1:0] cnt_q, hi_q;
  logic             publish, expire;

  logic [CNT_W-1:0] period_q, high_q, ref_p_q, ref_h_q;
  logic             period_vld_q, locked_q, ratio_err_q, timeout_q;
  logic [MW-1:0]    match_q, match_inc;
  logic             match_eq;

  // Input flop always present; the two extra stages only feed s when SYNC_EN.
  always_ff @(posedge clk_200K) begin
    if (!rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.clk_in};
      s_d    <= s;
    end
  end

  assign s    = (SYNC_EN != 0) ? sync_q[2] : sync_q[0];
  assign rise = s & ~s_d;

  always_ff @(posedge clk_200K) begin
    if (!rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
    end else if (rise) begin
      cnt_q <= ONE;
      hi_q  <= ONE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + ONE;
      if (s && hi_q != CNT_MAX) hi_q <= hi_q + ONE;
    end
  end

  always_ff @(posedge clk_200K) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A rise coinciding with counter saturation publishes instead of expiring.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = MEAS;
      MEAS, TRACK: begin
        if (rise) begin
          publish = 1'b1;
          state_d = TRACK;
        end else if (cnt_q == CNT_MAX) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign match_eq  = (match_q != '0) && (cnt_q == ref_p_q) && (hi_q == ref_h_q);
  assign match_inc = (match_q == LOCK_M) ? match_q : match_q + MW'(1);

  always_ff @(posedge clk_200K) begin
    if (!rst) begin
      period_q     <= '0;
      high_q       <= '0;
      ref_p_q      <= '0;
      ref_h_q      <= '0;
      match_q      <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      ratio_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      period_vld_q <= 1'b0;
      ratio_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      if (publish) begin
        period_q     <= cnt_q;
        high_q       <= hi_q;
        period_vld_q <= 1'b1;
        if (match_eq) begin
          match_q  <= match_inc;
          locked_q <= (match_inc == LOCK_M);
        end else begin
          match_q     <= MW'(1);
          ref_p_q     <= cnt_q;
          ref_h_q     <= hi_q;
          ratio_err_q <= locked_q;
          locked_q    <= !locked_q && (LOCK_M == MW'(1));
        end
      end else if (expire) begin
        timeout_q <= 1'b1;
        locked_q  <= 1'b0;
        match_q   <= '0;
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.period_vld = period_vld_q;
  assign bus.locked     = locked_q;
  assign bus.ratio_err  = ratio_err_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Scoreboard bench: clk_in is built from (high, low) period lists; expected
// publishes and timeouts are queued at each rise and checked by a monitor.
module tb_clk_ratio_detect;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LOCK_N = 4;
  localparam int          MAXC   = (1 << CNT_W) - 1;

  logic clk_200K = 1'b0;
  logic rst      = 1'b0;
  logic rst_q    = 1'b0;

  clk_ratio_detect_if #(.CNT_W(CNT_W)) bus ();

  clk_ratio_detect #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .SYNC_EN(0)) dut (
    .clk_200K (clk_200K),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_200K = ~clk_200K;
  always @(posedge clk_200K) rst_q <= rst;

  typedef struct {
    bit is_to;
    int p;
    int h;
    bit lk;
    bit err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  bit armed;
  int m, rp, rh, last_p, last_h, prev_l, prev_h;
  bit m_lk;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    armed  = 0;
    m      = 0;
    m_lk   = 0;
    rp     = 0;
    rh     = 0;
    last_p = 0;
    last_h = 0;
    prev_l = 0;
    prev_h = 0;
  endtask

  task automatic model_publish(int l, int h);
    exp_t e;
    e.is_to = 0;
    e.p     = l;
    e.h     = h;
    if (m > 0 && l == rp && h == rh) begin
      if (m < int'(LOCK_N)) m++;
      m_lk  = (m == int'(LOCK_N));
      e.err = 0;
    end else begin
      e.err = m_lk;
      m_lk  = 0;
      m     = 1;
      rp    = l;
      rh    = h;
    end
    e.lk   = m_lk;
    last_p = l;
    last_h = h;
    q.push_back(e);
  endtask

  task automatic cyc(bit v);
    bus.clk_in = v;
    @(posedge clk_200K);
    #1;
  endtask

  // Rising edge starts a period: it closes (publishes) the previous one.
  task automatic issue(int hh, int ll);
    exp_t e;
    int l;
    l = hh + ll;
    if (armed) model_publish(prev_l, prev_h);
    armed  = 1;
    prev_l = l;
    prev_h = hh;
    if (l > MAXC) begin
      e.is_to = 1;
      e.p     = last_p;
      e.h     = last_h;
      e.lk    = 0;
      e.err   = 0;
      q.push_back(e);
      armed = 0;
      m     = 0;
      m_lk  = 0;
    end
    repeat (hh) cyc(1'b1);
    repeat (ll) cyc(1'b0);
  endtask

  always @(negedge clk_200K) begin
    if (!rst_q) begin
      check("rst_period",    int'(bus.period),     0);
      check("rst_high_time", int'(bus.high_time),  0);
      check("rst_vld",       int'(bus.period_vld), 0);
      check("rst_locked",    int'(bus.locked),     0);
      check("rst_ratio_err", int'(bus.ratio_err),  0);
      check("rst_timeout",   int'(bus.timeout),    0);
    end else begin
      if (bus.period_vld) begin
        if (q.size() == 0 || q[0].is_to) begin
          check("unexpected_vld", 1, 0);
          if (q.size() != 0) void'(q.pop_front());
        end else begin
          mon_e = q.pop_front();
          check("period",    int'(bus.period),    mon_e.p);
          check("high_time", int'(bus.high_time), mon_e.h);
          check("locked",    int'(bus.locked),    int'(mon_e.lk));
          check("ratio_err", int'(bus.ratio_err), int'(mon_e.err));
        end
      end else begin
        check("err_without_vld", int'(bus.ratio_err), 0);
      end
      if (bus.timeout) begin
        if (q.size() == 0 || !q[0].is_to) begin
          check("unexpected_timeout", 1, 0);
          if (q.size() != 0) void'(q.pop_front());
        end else begin
          mon_e = q.pop_front();
          check("to_locked",    int'(bus.locked),    0);
          check("to_period",    int'(bus.period),    mon_e.p);
          check("to_high_time", int'(bus.high_time), mon_e.h);
        end
      end
    end
  end

  initial begin
    model_reset();
    bus.clk_in = 1'b0;
    @(posedge clk_200K);
    #1;
    // Reset held while clk_in toggles
    repeat (6) begin cyc(1'b1); cyc(1'b0); end
    repeat (3) cyc(1'b0);
    rst = 1'b1;

    repeat (8) issue(1, 1);
    repeat (8) issue(4, 4);
    repeat (6) issue(2, 2);
    repeat (6) issue(4, 4);

    // Stuck low after lock, then recovery
    repeat (6) issue(2, 2);
    issue(2, 300);
    repeat (6) issue(2, 2);

    // Saturation boundary: 255 publishes, 256 expires
    repeat (3) issue(10, 245);
    issue(10, 246);
    repeat (5) issue(3, 5);

    for (int i = 0; i < 30; i++) begin
      int hh, ll, n;
      hh = int'($urandom_range(1, 6));
      ll = int'($urandom_range(1, 6));
      n  = int'($urandom_range(1, 7));
      repeat (n) issue(hh, ll);
    end

    // Reset mid-period while locked
    repeat (6) issue(1, 1);
    if (armed) model_publish(prev_l, prev_h);
    repeat (5) cyc(1'b1);
    check("drained_before_rst", q.size(), 0);
    rst = 1'b0;
    repeat (2) cyc(1'b1);
    repeat (3) begin cyc(1'b0); cyc(1'b1); end
    repeat (3) cyc(1'b0);
    rst = 1'b1;
    model_reset();
    repeat (8) issue(1, 1);

    issue(1, 3);
    repeat (10) cyc(1'b0);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
